// File: rtl/button_led_ctrl.sv
// button_led_ctrl: synchronised, debounced two-button controller driving an active-low LED bank in four display modes
module button_led_ctrl #(
  parameter int unsigned N_LEDS          = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              button1,
  input  logic              button2,
  output logic [N_LEDS-1:0] led,
  output logic [1:0]        mode
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {MIRROR, TOGGLE, COUNT, SHIFT} mode_e;
  logic [1:0]          sync1_q, sync2_q, level_q, level_d, press;
  logic [1:0][CW-1:0]  dcnt_q, dcnt_d;
  mode_e               mode_q, mode_d;
  logic                tog_q, tog_d;
  logic [N_LEDS-1:0]   cnt_q, cnt_d, sh_q, sh_d, p, led_q;
  // index 0 is button1, index 1 is button2
  always_comb begin
    level_d = level_q;
    dcnt_d  = '0;
    for (int i = 0; i < 2; i++)
      if (sync2_q[i] != level_q[i]) begin
        if (dcnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) level_d[i] = sync2_q[i];
        else dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
  end
  assign press = level_q & ~level_d;
  // a mode change takes priority and discards a coincident button1 press
  always_comb begin
    mode_d = mode_q;
    tog_d  = tog_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    if (press[1]) begin
      mode_d = mode_e'(mode_q + 2'd1);
      tog_d  = 1'b0;
      cnt_d  = '0;
      sh_d   = N_LEDS'(1);
    end else if (press[0]) begin
      tog_d = (mode_q == TOGGLE) ? ~tog_q : tog_q;
      cnt_d = (mode_q == COUNT) ? cnt_q + 1'b1 : cnt_q;
      sh_d  = (mode_q == SHIFT) ? {sh_q[N_LEDS-2:0], sh_q[N_LEDS-1]} : sh_q;
    end
  end
  assign p = (mode_q == MIRROR) ? {N_LEDS{~level_q[0]}} :
             (mode_q == TOGGLE) ? {N_LEDS{tog_q}} :
             (mode_q == COUNT)  ? cnt_q : sh_q;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      level_q <= 2'b11;
      dcnt_q  <= '0;
      mode_q  <= MIRROR;
      tog_q   <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= N_LEDS'(1);
      led_q   <= '1;
    end else begin
      sync1_q <= {button2, button1};
      sync2_q <= sync1_q;
      level_q <= level_d;
      dcnt_q  <= dcnt_d;
      mode_q  <= mode_d;
      tog_q   <= tog_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      led_q   <= ~p;
    end
  assign led  = led_q;
  assign mode = mode_q;
endmodule

// File: tb/tb_button_led_ctrl.sv
// tb_button_led_ctrl: vector table, directed sequences and random stimulus against a sliding-window reference model
module tb_button_led_ctrl;
  localparam int D = 4;
  localparam int N = 6;
  localparam int ALL = (1 << N) - 1;
  logic sys_clk = 0, sys_rst_n = 0, button1 = 1, button2 = 1;
  logic [N-1:0] led;
  logic [1:0] mode;
  int n_pass = 0, n_total = 0;
  button_led_ctrl #(.N_LEDS(N), .DEBOUNCE_CYCLES(D)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .button1(button1), .button2(button2),
    .led(led), .mode(mode)
  );
  always #5 sys_clk = ~sys_clk;
  // reference model: a level flips once the last D raw samples seen by the synchroniser all disagree with it
  logic [1:0] hist[$];
  logic [1:0] m_lvl;
  int m_mode, m_tog, m_cnt, m_pos, exp_led;
  typedef struct {logic b1; logic b2; logic [N-1:0] led; logic [1:0] mode;} vec_t;
  vec_t tbl[15];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(2'b11);
    m_lvl = 2'b11; m_mode = 0; m_tog = 0; m_cnt = 0; m_pos = 0;
  endtask
  function automatic int pattern();
    case (m_mode)
      0: return m_lvl[0] ? 0 : ALL;
      1: return m_tog ? ALL : 0;
      2: return m_cnt;
      default: return 1 << m_pos;
    endcase
  endfunction
  task automatic model_edge(input logic b1, input logic b2);
    logic [1:0] nl, pr;
    bit flip;
    int n;
    exp_led = ALL & ~pattern();
    hist.push_back({b2, b1});
    if (hist.size() > D + 3) void'(hist.pop_front());
    n = hist.size();
    for (int i = 0; i < 2; i++) begin
      flip = 1;
      for (int j = n - D - 2; j <= n - 3; j++) if (hist[j][i] == m_lvl[i]) flip = 0;
      nl[i] = flip ? ~m_lvl[i] : m_lvl[i];
    end
    pr = m_lvl & ~nl;
    m_lvl = nl;
    if (pr[1]) begin
      m_mode = (m_mode + 1) % 4; m_tog = 0; m_cnt = 0; m_pos = 0;
    end else if (pr[0]) begin
      if (m_mode == 1) m_tog = 1 - m_tog;
      if (m_mode == 2) m_cnt = (m_cnt + 1) % (ALL + 1);
      if (m_mode == 3) m_pos = (m_pos + 1) % N;
    end
  endtask
  task automatic step(input logic b1, input logic b2);
    button1 = b1; button2 = b2;
    @(posedge sys_clk);
    model_edge(b1, b2);
    #1;
    chk("model_led", led, exp_led);
    chk("model_mode", mode, m_mode);
  endtask
  task automatic press(input logic [1:0] which);
    for (int i = 0; i < D + 4; i++) step(~which[0], ~which[1]);
    for (int i = 0; i < D + 4; i++) step(1'b1, 1'b1);
  endtask
  task automatic goto_mode(input int m);
    for (int i = 0; i < 4 && m_mode != m; i++) press(2'b10);
    chk("goto_mode", mode, m);
  endtask
  initial begin
    for (int i = 0; i < 15; i++) begin
      tbl[i].b1   = (i < 8) ? 1'b0 : 1'b1;
      tbl[i].b2   = 1'b1;
      tbl[i].led  = (i < 6 || i == 14) ? 6'b111111 : 6'b000000;
      tbl[i].mode = 2'd0;
    end
    model_reset();
    @(posedge sys_clk); #1;
    chk("reset_led", led, ALL);
    chk("reset_mode", mode, 0);
    sys_rst_n = 1;
    // mirror latency: edge k of the table is row k-1
    foreach (tbl[i]) begin
      step(tbl[i].b1, tbl[i].b2);
      chk($sformatf("tbl_led[%0d]", i), led, tbl[i].led);
      chk($sformatf("tbl_mode[%0d]", i), mode, tbl[i].mode);
    end
    for (int w = 1; w <= 3; w++) begin
      for (int i = 0; i < w; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
        step(1'b1, 1'b1);
        chk("glitch_led", led, ALL);
      end
    end
    chk("glitch_mode", mode, 0);
    press(2'b10);
    chk("toggle_mode", mode, 1);
    press(2'b01); chk("toggle_1", led, 6'b000000);
    press(2'b01); chk("toggle_2", led, 6'b111111);
    press(2'b01); chk("toggle_3", led, 6'b000000);
    press(2'b10);
    chk("count_mode", mode, 2);
    chk("count_start", led, 6'b111111);
    for (int k = 1; k <= 65; k++) begin
      press(2'b01);
      if (k == 63) chk("count_63", led, 6'b000000);
      if (k == 64) chk("count_wrap", led, 6'b111111);
    end
    chk("count_65", led, 6'b111110);
    press(2'b10);
    chk("shift_mode", mode, 3);
    chk("shift_start", led, 6'b111110);
    for (int k = 1; k <= 7; k++) begin
      press(2'b01);
      if (k == 6) chk("shift_wrap", led, 6'b111110);
    end
    chk("shift_7", led, 6'b111101);
    press(2'b11);
    chk("simul_mode", mode, 0);
    chk("simul_led", led, 6'b111111);
    goto_mode(3);
    chk("simul_sh_reset", led, 6'b111110);
    goto_mode(2);
    for (int k = 0; k < 5; k++) press(2'b01);
    chk("cnt5_led", led, 6'b111010);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    sys_rst_n = 0;
    #2;
    chk("midrst_led", led, ALL);
    chk("midrst_mode", mode, 0);
    model_reset();
    #1 sys_rst_n = 1;
    for (int i = 1; i <= D + 3; i++) begin
      step(1'b0, 1'b1);
      if (i == D + 2) chk("post_rst_pre", led, 6'b111111);
    end
    chk("post_rst_pressed", led, 6'b000000);
    press(2'b10);
    chk("held_no_repeat_mode", mode, 1);
    chk("held_no_repeat_led", led, 6'b111111);
    for (int i = 0; i < D + 4; i++) step(1'b1, 1'b1);
    chk("release_no_event", led, 6'b111111);
    for (int s = 0; s < 400; s++) begin
      logic b1, b2;
      int len;
      b1 = 1'($urandom_range(0, 1));
      b2 = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) step(b1, b2);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
